// File: rtl/dpram_fifo_arb.sv
// dpram_fifo_arb
// Two-requester FIFO front end for an external single-clock simple dual-port
// RAM. A round-robin arbiter picks one writer per cycle; the read side pops
// one word per accepted request and returns it one cycle later straight from
// the RAM read port.
//
// Ports
//   clk, rst                : single clock, asynchronous active-high reset
//   s0_* / s1_*             : requester write channels (data, valid, ready)
//   rd_req                  : consumer pop request
//   rd_data_o, rd_valid     : popped word and its qualifier (1-cycle latency)
//   flush                   : synchronous clear, overrides everything else
//   ram_wr_* / ram_rd_*     : external RAM write port and read port
//   count, full, empty      : occupancy and its derived flags
//   almost_full             : count >= AFULL_LEVEL
//   udf_err                 : sticky, set by a pop request while empty
module dpram_fifo_arb #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int AFULL_LEVEL = 1008
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  udf_err
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_COUNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arbState_t;

  arbState_t             r_state;
  arbState_t             w_nextState;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rdValid;
  logic                  r_udfErr;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_block;
  logic                  w_wrAccept;
  logic                  w_rdAccept;
  logic                  w_full;
  logic                  w_empty;

  // Flags come from the registered count only, never from this cycle's traffic.
  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= AFULL_COUNT);
  assign count       = r_count;
  assign udf_err     = r_udfErr;
  assign rd_valid    = r_rdValid;
  assign rd_data_o   = ram_rd_data;
  assign ram_wr_addr = r_wptr;
  assign ram_rd_addr = r_rptr;

  // rst is included so the ready outputs are low while reset is held,
  // independent of what the requesters are driving.
  assign w_block    = rst | w_full | flush;
  assign w_wrAccept = s0_ready | s1_ready;
  assign w_rdAccept = rd_req & ~w_empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LAST1;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Round-robin: on a tie the requester not recorded as last wins. The state
  // only moves on an accepted write, so a blocked grant does not cost a turn.
  always_comb begin
    w_nextState = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_data = s0_data;

    if (s0_valid && s1_valid) begin
      if (r_state == LAST1) begin
        w_grant0 = 1'b1;
      end else begin
        w_grant1 = 1'b1;
      end
    end else if (s0_valid) begin
      w_grant0 = 1'b1;
    end else if (s1_valid) begin
      w_grant1 = 1'b1;
    end

    s0_ready  = w_grant0 & ~w_block;
    s1_ready  = w_grant1 & ~w_block;
    ram_wr_en = s0_ready | s1_ready;
    if (s1_ready) begin
      ram_wr_data = s1_data;
    end

    if (flush) begin
      w_nextState = LAST1;
    end else if (s0_ready) begin
      w_nextState = LAST0;
    end else if (s1_ready) begin
      w_nextState = LAST1;
    end
  end

  // Pointers wrap naturally at their width. A pop request on an empty FIFO
  // is dropped and latches udf_err until flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rdValid <= 1'b0;
      r_udfErr  <= 1'b0;
    end else if (flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rdValid <= 1'b0;
      r_udfErr  <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rdAccept) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rdValid <= w_rdAccept;
      if (rd_req && w_empty) begin
        r_udfErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_arb.sv
// tb_dpram_fifo_arb
// Directed bench for dpram_fifo_arb with a behavioural 1024x8 RAM that
// registers its read address (one-cycle read latency).
module tb_dpram_fifo_arb;

  logic        clk;
  logic        rst;
  logic [7:0]  s0_data;
  logic        s0_valid;
  logic        s0_ready;
  logic [7:0]  s1_data;
  logic        s1_valid;
  logic        s1_ready;
  logic        rd_req;
  logic [7:0]  rd_data_o;
  logic        rd_valid;
  logic        flush;
  logic [7:0]  ram_wr_data;
  logic [9:0]  ram_wr_addr;
  logic        ram_wr_en;
  logic [9:0]  ram_rd_addr;
  logic [7:0]  ram_rd_data;
  logic [10:0] count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        udf_err;

  int testsRun;
  int testsFailed;

  logic [7:0] mem [0:1023];
  logic [7:0] refQ [$];

  dpram_fifo_arb #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(8),
    .AFULL_LEVEL(1008)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s0_data(s0_data),
    .s0_valid(s0_valid),
    .s0_ready(s0_ready),
    .s1_data(s1_data),
    .s1_valid(s1_valid),
    .s1_ready(s1_ready),
    .rd_req(rd_req),
    .rd_data_o(rd_data_o),
    .rd_valid(rd_valid),
    .flush(flush),
    .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .udf_err(udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: synchronous write, registered read address.
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_rd_addr];
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic applyStimulus(input logic s0v, input logic [7:0] s0d,
                               input logic s1v, input logic [7:0] s1d,
                               input logic rq, input logic fl);
    s0_valid = s0v;
    s0_data  = s0d;
    s1_valid = s1v;
    s1_data  = s1d;
    rd_req   = rq;
    flush    = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Reset state, with both requesters and a pop request held active.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s0_ready", s0_ready, 0);
    checkOutput("rst_s1_ready", s1_ready, 0);
    checkOutput("rst_wr_en", ram_wr_en, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_afull", almost_full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_udf", udf_err, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Fairness: both valid for 8 cycles, grants alternate starting with s0.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
      #2;
      checkOutput("fair_s0_ready", s0_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput("fair_s1_ready", s1_ready, (i % 2 == 0) ? 0 : 1);
      checkOutput("fair_wr_en", ram_wr_en, 1);
      checkOutput("fair_wr_addr", ram_wr_addr, i);
      checkOutput("fair_wr_data", ram_wr_data, (i % 2 == 0) ? (32'hA0 + i) : (32'hB0 + i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fair_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("fair_rd_valid", rd_valid, 1);
      checkOutput("fair_rd_data", rd_data_o, (i % 2 == 0) ? (32'hA0 + i) : (32'hB0 + i));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("fair_end_rd_valid", rd_valid, 0);
    checkOutput("fair_end_empty", empty, 1);

    // Ordering: 0x11, 0x22, 0x33 in, then three pops.
    applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ord_pre_rd_valid", rd_valid, 0);
    tick();
    checkOutput("ord_rd_valid0", rd_valid, 1);
    checkOutput("ord_data0", rd_data_o, 32'h11);
    tick();
    checkOutput("ord_rd_valid1", rd_valid, 1);
    checkOutput("ord_data1", rd_data_o, 32'h22);
    tick();
    checkOutput("ord_rd_valid2", rd_valid, 1);
    checkOutput("ord_data2", rd_data_o, 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("ord_end_rd_valid", rd_valid, 0);
    checkOutput("ord_end_empty", empty, 1);

    // Flush right after an accepted pop kills the pending rd_valid.
    applyStimulus(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("fl_pending_valid", rd_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("fl_rd_valid", rd_valid, 0);
    checkOutput("fl_count", count, 0);

    // Underflow with a simultaneous write on s0.
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    checkOutput("udf_wr_accept", s0_ready, 1);
    tick();
    checkOutput("udf_rd_valid", rd_valid, 0);
    checkOutput("udf_set", udf_err, 1);
    checkOutput("udf_count", count, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("udf_sticky", udf_err, 1);
    checkOutput("udf_rd_valid2", rd_valid, 0);
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 1'b1);
    #2;
    checkOutput("flush_s0_ready", s0_ready, 0);
    checkOutput("flush_s1_ready", s1_ready, 0);
    checkOutput("flush_wr_en", ram_wr_en, 0);
    tick();
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 1'b0);
    checkOutput("flush_udf_clr", udf_err, 0);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1);
    #2;
    checkOutput("flush_arb_s0", s0_ready, 1);
    checkOutput("flush_arb_s1", s1_ready, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Full: 1024 writes via s0.
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b1, 8'(i ^ 8'h5C), 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      if (i == 1006) checkOutput("af_below", almost_full, 0);
      if (i == 1007) checkOutput("af_at_level", almost_full, 1);
      if (i == 1022) checkOutput("full_at_1023", full, 0);
    end
    checkOutput("full_flag", full, 1);
    checkOutput("full_count", count, 1024);
    checkOutput("full_af", almost_full, 1);
    checkOutput("full_empty", empty, 0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 8'hEE, 1'b0, 1'b0);
    #2;
    checkOutput("full_s0_ready", s0_ready, 0);
    checkOutput("full_s1_ready", s1_ready, 0);
    checkOutput("full_wr_en", ram_wr_en, 0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    checkOutput("full_rw_s0_ready", s0_ready, 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("full_rw_count", count, 1023);
    checkOutput("full_rw_full", full, 0);
    checkOutput("full_rw_valid", rd_valid, 1);
    checkOutput("full_rw_data", rd_data_o, 32'h5C);

    // Wrap: 1500 words streamed through with a one-cycle-behind pop.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("wrap_flush_count", count, 0);
    refQ.delete();
    for (int i = 0; i < 1502; i++) begin
      logic       wv;
      logic       rq;
      logic [7:0] d;
      logic [7:0] expData;
      wv = (i < 1500);
      rq = (i >= 1) && (i <= 1500);
      d  = 8'(i * 7 + 3);
      if (wv) refQ.push_back(d);
      applyStimulus(wv, d, 1'b0, 8'h00, rq, 1'b0);
      if (i == 1025) begin
        #2;
        checkOutput("wrap_wr_addr", ram_wr_addr, 1);
        checkOutput("wrap_rd_addr", ram_rd_addr, 0);
      end
      tick();
      if (i >= 1 && i <= 1500) begin
        checkOutput("wrap_rd_valid", rd_valid, 1);
        expData = (refQ.size() > 0) ? refQ.pop_front() : 8'hxx;
        checkOutput("wrap_rd_data", rd_data_o, expData);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("wrap_end_valid", rd_valid, 0);
    checkOutput("wrap_end_empty", empty, 1);
    checkOutput("wrap_end_udf", udf_err, 0);
    checkOutput("wrap_queue_empty", refQ.size(), 0);

    // Reset mid-stream with count = 5 and a pop in flight.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid_pre_count", count, 5);
    checkOutput("mid_pre_valid", rd_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", rd_valid, 0);
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_empty", empty, 1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b0, 1'b0);
    #2;
    checkOutput("post_rst_wr_addr", ram_wr_addr, 0);
    checkOutput("post_rst_s0_wins", s0_ready, 1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_rst_count", count, 1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_rst_valid", rd_valid, 1);
    checkOutput("post_rst_data", rd_data_o, 32'hC3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
